// File: rtl/mips_mc_core.sv
// mips_mc_core: multicycle MIPS subset core; one shared memory port serves fetch and data.
// Optional feature macro MIPS_JAL_EN adds jal (opcode 6'h03); without it that opcode traps to ERR.
module mips_mc_core #(
  parameter logic [31:0] RESET_VECTOR = 32'h00400000,
  parameter int unsigned MEM_WAIT_EN  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic [31:0] pc,
  output logic [3:0]  state,
  output logic        retire,
  output logic        illegal_op
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_EXEC    = 4'd2;
  localparam logic [3:0] S_RWB     = 4'd3;
  localparam logic [3:0] S_ADDI_EX = 4'd4;
  localparam logic [3:0] S_ADDI_WB = 4'd5;
  localparam logic [3:0] S_MEMADR  = 4'd6;
  localparam logic [3:0] S_MEMRD   = 4'd7;
  localparam logic [3:0] S_MEMWB   = 4'd8;
  localparam logic [3:0] S_MEMWR   = 4'd9;
  localparam logic [3:0] S_BRANCH  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_ERR     = 4'd12;
`ifdef MIPS_JAL_EN
  localparam logic [3:0] S_JAL     = 4'd13;
  localparam logic [5:0] OP_JAL    = 6'h03;
`endif

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2a;

  logic [31:0] ir;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] mdr;
  logic [31:0] alu_out;
  logic [31:0] regs [32];
  logic [3:0]  next_state;
  logic        ready;
  logic        funct_ok;
  logic        retire_state;
  logic [31:0] alu_result;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [31:0] imm_sext;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] jump_target;

  assign ready       = (MEM_WAIT_EN == 0) ? 1'b1 : mem_ready;
  assign opcode      = ir[31:26];
  assign rs          = ir[25:21];
  assign rt          = ir[20:16];
  assign rd          = ir[15:11];
  assign shamt       = ir[10:6];
  assign funct       = ir[5:0];
  assign imm_sext    = {{16{ir[15]}}, ir[15:0]};
  assign rs_val      = (rs == 5'd0) ? 32'd0 : regs[rs];
  assign rt_val      = (rt == 5'd0) ? 32'd0 : regs[rt];
  assign jump_target = {pc[31:28], ir[25:0], 2'b00};

  always_comb begin
    alu_result = 32'd0;
    funct_ok   = 1'b1;
    case (funct)
      F_ADD:   alu_result = a_reg + b_reg;
      F_SUB:   alu_result = a_reg - b_reg;
      F_AND:   alu_result = a_reg & b_reg;
      F_OR:    alu_result = a_reg | b_reg;
      F_SLT:   alu_result = {31'd0, $signed(a_reg) < $signed(b_reg)};
      F_SLL:   alu_result = b_reg << shamt;
      F_SRL:   alu_result = b_reg >> shamt;
      default: funct_ok = 1'b0;
    endcase
  end

  // Unsupported funct codes are caught at dispatch so EXEC only ever sees legal ops.
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH: if (ready) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      next_state = funct_ok ? S_EXEC : S_ERR;
          OP_ADDI:       next_state = S_ADDI_EX;
          OP_LW, OP_SW:  next_state = S_MEMADR;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_J:          next_state = S_JUMP;
`ifdef MIPS_JAL_EN
          OP_JAL:        next_state = S_JAL;
`endif
          default:       next_state = S_ERR;
        endcase
      end
      S_EXEC:    next_state = S_RWB;
      S_ADDI_EX: next_state = S_ADDI_WB;
      S_MEMADR:  next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (ready) next_state = S_MEMWB;
      S_MEMWR:   if (ready) next_state = S_FETCH;
      S_RWB, S_ADDI_WB, S_MEMWB, S_BRANCH, S_JUMP: next_state = S_FETCH;
`ifdef MIPS_JAL_EN
      S_JAL:     next_state = S_FETCH;
`endif
      default:   next_state = S_ERR;
    endcase
  end

  always_comb begin
    retire_state = 1'b0;
    case (state)
      S_RWB, S_ADDI_WB, S_MEMWB, S_BRANCH, S_JUMP: retire_state = 1'b1;
      S_MEMWR: retire_state = ready;
`ifdef MIPS_JAL_EN
      S_JAL:   retire_state = 1'b1;
`endif
      default: retire_state = 1'b0;
    endcase
  end

  // Gating with rst keeps the port quiet during reset, so a stalled store is abandoned.
  assign mem_req     = rst & ((state == S_FETCH) | (state == S_MEMRD) | (state == S_MEMWR));
  assign mem_we      = rst & (state == S_MEMWR);
  assign mem_addr    = ((state == S_MEMRD) || (state == S_MEMWR)) ? alu_out : pc;
  assign mem_wr_data = b_reg;
  assign retire      = rst & retire_state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_FETCH;
      pc         <= RESET_VECTOR;
      ir         <= 32'd0;
      a_reg      <= 32'd0;
      b_reg      <= 32'd0;
      mdr        <= 32'd0;
      alu_out    <= 32'd0;
      illegal_op <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      state      <= next_state;
      illegal_op <= (next_state == S_ERR);
      case (state)
        S_FETCH: begin
          if (ready) begin
            ir <= mem_rd_data;
            pc <= pc + 32'd4;
          end
        end
        S_DECODE: begin
          a_reg   <= rs_val;
          b_reg   <= rt_val;
          alu_out <= pc + {imm_sext[29:0], 2'b00};
        end
        S_EXEC:              alu_out <= alu_result;
        S_ADDI_EX, S_MEMADR: alu_out <= a_reg + imm_sext;
        S_RWB:     if (rd != 5'd0) regs[rd] <= alu_out;
        S_ADDI_WB: if (rt != 5'd0) regs[rt] <= alu_out;
        S_MEMRD:   if (ready) mdr <= mem_rd_data;
        S_MEMWB:   if (rt != 5'd0) regs[rt] <= mdr;
        // beq takes the branch on equality, bne on inequality.
        S_BRANCH:  if ((opcode == OP_BEQ) == (a_reg == b_reg)) pc <= alu_out;
        S_JUMP:    pc <= jump_target;
`ifdef MIPS_JAL_EN
        S_JAL: begin
          regs[31] <= pc;
          pc       <= jump_target;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_core.sv
// tb_mips_mc_core: directed and random programs checked against an instruction-level model.
// Memory map: code at 0x00400000 (imem), data below 0x1000 (dmem).
module tb_mips_mc_core;

  localparam logic [31:0] RV   = 32'h00400000;
  localparam logic [31:0] SPIN = 32'h1000FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_rd_data;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] pc;
  logic [3:0]  state;
  logic        retire;
  logic        illegal_op;

  mips_mc_core dut (
    .clk(clk), .rst(rst), .mem_rd_data(mem_rd_data), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .pc(pc), .state(state), .retire(retire), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [256];
  logic [31:0] dmem [1024];
  logic [31:0] mDmem [1024];
  logic [31:0] mRegs [32];
  logic [31:0] mPc;
  logic [31:0] wrAddrQ [$];
  logic [31:0] wrDataQ [$];
  int checkCount = 0;
  int errorCount = 0;
  int cycleCount = 0;
  int stallCount = 0;
  int retireCount = 0;
  int stallData = 0;
  bit randWait = 1'b0;
  logic lastReq = 1'b0;
  logic lastWe = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memRead(input logic [31:0] addr);
    if (addr[31:12] == 20'h00400) return imem[addr[9:2]];
    if (addr[31:12] == 20'h00000) return dmem[addr[11:2]];
    return 32'hDEADBEEF;
  endfunction

  function automatic logic [31:0] encR(input logic [5:0] fn, input int rs, input int rt, input int rd, input int sh);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] encI(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] encJ(input logic [5:0] op, input logic [31:0] target);
    return {op, target[27:2]};
  endfunction

  // One clock: memory responds at negedge, outputs sampled 1ns later.
  task automatic applyStimulus();
    @(negedge clk);
    mem_ready = 1'b1;
    if (mem_req) begin
      if (stallData > 0 && mem_addr[31:12] == 20'h00000) begin
        mem_ready = 1'b0;
        stallData--;
      end else if (randWait && $urandom_range(0, 3) == 0) begin
        mem_ready = 1'b0;
      end
    end
    mem_rd_data = mem_req ? memRead(mem_addr) : $urandom();
    #1;
    cycleCount++;
    lastReq = mem_req;
    lastWe  = mem_we;
    if (mem_req && !mem_ready) stallCount++;
    if (retire) retireCount++;
    if (mem_req && mem_we && mem_ready) begin
      wrAddrQ.push_back(mem_addr);
      wrDataQ.push_back(mem_wr_data);
      if (mem_addr[31:12] == 20'h00000) dmem[mem_addr[11:2]] = mem_wr_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b0;
    applyStimulus();
    checkOutput("rst_req", {31'd0, lastReq}, 32'd0);
    checkOutput("rst_we", {31'd0, lastWe}, 32'd0);
    applyStimulus();
    rst = 1'b1;
    #1;
    checkOutput("rst_pc", pc, RV);
    checkOutput("rst_req_fetch", {31'd0, mem_req}, 32'd1);
    checkOutput("rst_addr", mem_addr, RV);
    checkOutput("rst_illegal", {31'd0, illegal_op}, 32'd0);
    checkOutput("rst_retire", {31'd0, retire}, 32'd0);
    mPc = RV;
    for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
  endtask

  task automatic loadSpin();
    for (int i = 0; i < 256; i++) imem[i] = SPIN;
  endtask

  task automatic initData();
    for (int i = 0; i < 1024; i++) begin
      dmem[i]  = $urandom();
      mDmem[i] = dmem[i];
    end
  endtask

  task automatic setReg(input int r, input logic [31:0] v);
    if (r != 0) mRegs[r] = v;
  endtask

  // Instruction-set level reference: architectural effect plus nominal latency.
  task automatic modelStep(output logic [31:0] npc, output int lat, output bit wr,
                           output logic [31:0] wa, output logic [31:0] wd);
    logic [31:0] ins, a, b, simm, res, seq, ad;
    logic [5:0]  op, fn;
    int rs, rt, rd, sh;
    ins  = imem[mPc[9:2]];
    op   = ins[31:26];
    fn   = ins[5:0];
    rs   = int'(ins[25:21]);
    rt   = int'(ins[20:16]);
    rd   = int'(ins[15:11]);
    sh   = int'(ins[10:6]);
    a    = mRegs[rs];
    b    = mRegs[rt];
    simm = {{16{ins[15]}}, ins[15:0]};
    seq  = mPc + 32'd4;
    npc  = seq;
    wr   = 1'b0;
    wa   = 32'd0;
    wd   = 32'd0;
    lat  = 0;
    res  = 32'd0;
    case (op)
      6'h00: begin
        lat = 4;
        case (fn)
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h2a: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h00: res = b << sh;
          6'h02: res = b >> sh;
          default: res = 32'd0;
        endcase
        setReg(rd, res);
      end
      6'h08: begin
        lat = 4;
        setReg(rt, a + simm);
      end
      6'h23: begin
        lat = 5;
        ad = a + simm;
        setReg(rt, mDmem[ad[11:2]]);
      end
      6'h2b: begin
        lat = 4;
        wr = 1'b1;
        wa = a + simm;
        wd = b;
        mDmem[wa[11:2]] = b;
      end
      6'h04: begin
        lat = 3;
        if (a == b) npc = seq + (simm << 2);
      end
      6'h05: begin
        lat = 3;
        if (a != b) npc = seq + (simm << 2);
      end
      6'h02: begin
        lat = 3;
        npc = {seq[31:28], ins[25:0], 2'b00};
      end
`ifdef MIPS_JAL_EN
      6'h03: begin
        lat = 3;
        setReg(31, seq);
        npc = {seq[31:28], ins[25:0], 2'b00};
      end
`endif
      default: lat = 0;
    endcase
    mPc = npc;
  endtask

  task automatic runOne(output int lat);
    logic [31:0] expPc, wa, wd;
    int expLat, c0, s0, r0, w0, budget;
    bit expWr;
    modelStep(expPc, expLat, expWr, wa, wd);
    c0 = cycleCount;
    s0 = stallCount;
    r0 = retireCount;
    w0 = wrAddrQ.size();
    budget = 0;
    while (retireCount == r0 && budget < 64) begin
      applyStimulus();
      budget++;
    end
    checkOutput("retire", 32'(retireCount - r0), 32'd1);
    lat = cycleCount - c0;
    checkOutput("latency", 32'(lat), 32'(expLat + (stallCount - s0)));
    checkOutput("pc", pc, expPc);
    checkOutput("wr_cnt", 32'(wrAddrQ.size() - w0), {31'd0, expWr});
    if (expWr && wrAddrQ.size() > w0) begin
      checkOutput("wr_addr", wrAddrQ[w0], wa);
      checkOutput("wr_data", wrDataQ[w0], wd);
    end
  endtask

  task automatic illegalCheck(input string tag, input logic [31:0] expPc);
    int r0, w0, budget;
    r0 = retireCount;
    w0 = wrAddrQ.size();
    budget = 0;
    while (!illegal_op && budget < 10) begin
      applyStimulus();
      budget++;
    end
    checkOutput({tag, "_flag"}, {31'd0, illegal_op}, 32'd1);
    repeat (4) applyStimulus();
    checkOutput({tag, "_hold"}, {31'd0, illegal_op}, 32'd1);
    checkOutput({tag, "_req"}, {31'd0, lastReq}, 32'd0);
    checkOutput({tag, "_pc"}, pc, expPc);
    checkOutput({tag, "_retire"}, 32'(retireCount - r0), 32'd0);
    checkOutput({tag, "_wr"}, 32'(wrAddrQ.size() - w0), 32'd0);
  endtask

  task automatic genRandom(input int n);
    int kind, r1, r2, r3;
    logic [5:0] fn;
    loadSpin();
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 5);
      r1 = $urandom_range(0, 7);
      r2 = $urandom_range(0, 7);
      r3 = $urandom_range(0, 7);
      case ($urandom_range(0, 6))
        0: fn = 6'h20;
        1: fn = 6'h22;
        2: fn = 6'h24;
        3: fn = 6'h25;
        4: fn = 6'h2a;
        5: fn = 6'h00;
        default: fn = 6'h02;
      endcase
      case (kind)
        0, 1: imem[i] = encR(fn, r1, r2, r3, $urandom_range(0, 31));
        2: imem[i] = encI(6'h08, r1, r2, 16'($urandom()));
        3: imem[i] = encI(6'h23, 0, r2, 16'($urandom_range(0, 127) * 4));
        4: imem[i] = encI(6'h2b, 0, r2, 16'(32'h200 + $urandom_range(0, 63) * 4));
        default: imem[i] = encI(($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05, r1, r2, 16'd1);
      endcase
    end
    for (int r = 0; r < 8; r++) imem[n + r] = encI(6'h2b, 0, r, 16'(32'h300 + 4 * r));
  endtask

  initial begin
    int lat, t0, r0, w0, budget, iter;
    logic [31:0] word;
    rst = 1'b0;
    mem_ready = 1'b0;
    mem_rd_data = 32'd0;

    // Straight-line program ending in a store of 5+7.
    loadSpin();
    initData();
    dmem[0] = 32'd0;
    mDmem[0] = 32'd0;
    imem[0] = encI(6'h08, 0, 1, 16'd5);
    imem[1] = encI(6'h08, 0, 2, 16'd7);
    imem[2] = encR(6'h20, 1, 2, 3, 0);
    imem[3] = encI(6'h2b, 0, 3, 16'd0);
    applyReset();
    t0 = cycleCount;
    r0 = retireCount;
    repeat (4) runOne(lat);
    checkOutput("prog_cycles", 32'(cycleCount - t0), 32'd16);
    checkOutput("prog_retires", 32'(retireCount - r0), 32'd4);
    checkOutput("sw12_data", dmem[0], 32'd12);

    // Load held off for three cycles in the data phase.
    loadSpin();
    initData();
    word = $urandom();
    dmem[16] = word;
    mDmem[16] = word;
    imem[0] = encI(6'h23, 0, 5, 16'h0040);
    imem[1] = encI(6'h2b, 0, 5, 16'h0200);
    applyReset();
    stallData = 3;
    runOne(lat);
    checkOutput("lw_lat", 32'(lat), 32'd8);
    runOne(lat);
    checkOutput("lw_value", dmem[32'h200 >> 2], word);

    // Branches and jump.
    loadSpin();
    imem[0] = encI(6'h08, 0, 1, 16'd9);
    imem[1] = encI(6'h04, 1, 1, 16'hFFFF);
    applyReset();
    runOne(lat);
    runOne(lat);
    checkOutput("beq_lat", 32'(lat), 32'd3);
    checkOutput("beq_pc", pc, RV + 32'd4);
    loadSpin();
    imem[0] = encI(6'h05, 1, 1, 16'd5);
    imem[1] = encI(6'h08, 0, 2, 16'd1);
    imem[2] = encI(6'h05, 2, 0, 16'd3);
    imem[6] = encJ(6'h02, RV + 32'h40);
    applyReset();
    runOne(lat);
    checkOutput("bne_lat", 32'(lat), 32'd3);
    checkOutput("bne_pc", pc, RV + 32'd4);
    runOne(lat);
    runOne(lat);
    checkOutput("bne_taken_pc", pc, RV + 32'd24);
    runOne(lat);
    checkOutput("j_lat", 32'(lat), 32'd3);
    checkOutput("j_pc", pc, RV + 32'h40);

    // Register 0 ignores writes.
    loadSpin();
    initData();
    imem[0] = encI(6'h08, 0, 0, 16'd5);
    imem[1] = encI(6'h2b, 0, 0, 16'h0204);
    applyReset();
    runOne(lat);
    runOne(lat);
    checkOutput("r0_zero", dmem[32'h204 >> 2], 32'd0);

    // Opcode 6'h03.
    loadSpin();
    initData();
    imem[0] = encJ(6'h03, RV + 32'h20);
    imem[8] = encI(6'h2b, 0, 31, 16'h0300);
    applyReset();
`ifdef MIPS_JAL_EN
    runOne(lat);
    checkOutput("jal_lat", 32'(lat), 32'd3);
    checkOutput("jal_pc", pc, RV + 32'h20);
    runOne(lat);
    checkOutput("jal_ra", dmem[32'h300 >> 2], RV + 32'd4);
`else
    illegalCheck("jal_illegal", RV + 32'd4);
`endif

    // Unsupported funct and opcode.
    loadSpin();
    imem[0] = encI(6'h08, 0, 1, 16'd3);
    imem[1] = encR(6'h21, 1, 1, 3, 0);
    applyReset();
    runOne(lat);
    illegalCheck("funct_illegal", RV + 32'd8);
    loadSpin();
    imem[0] = 32'hFC000000;
    applyReset();
    illegalCheck("op_illegal", RV + 32'd4);

    // Reset while a store is stalled.
    loadSpin();
    initData();
    dmem[32'h240 >> 2] = 32'd0;
    mDmem[32'h240 >> 2] = 32'd0;
    imem[0] = encI(6'h08, 0, 1, 16'h0055);
    imem[1] = encI(6'h2b, 0, 1, 16'h0240);
    applyReset();
    runOne(lat);
    stallData = 100;
    budget = 0;
    applyStimulus();
    while (!lastWe && budget < 10) begin
      applyStimulus();
      budget++;
    end
    checkOutput("memwr_reached", {31'd0, lastWe}, 32'd1);
    applyStimulus();
    w0 = wrAddrQ.size();
    stallData = 0;
    applyReset();
    checkOutput("rst_nowrite", 32'(wrAddrQ.size() - w0), 32'd0);
    checkOutput("rst_nomem", dmem[32'h240 >> 2], 32'd0);
    runOne(lat);
    runOne(lat);
    checkOutput("resume_store", dmem[32'h240 >> 2], 32'h55);

    // Random programs with random memory wait states.
    randWait = 1'b1;
    repeat (3) begin
      initData();
      genRandom(24);
      applyReset();
      iter = 0;
      while (mPc < RV + 32'd128 && iter < 100) begin
        runOne(lat);
        iter++;
      end
    end
    randWait = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/mips_mc_core.md
MIPS_MC_CORE -- requirements
Module: mips_mc_core

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h00400000, is the PC value loaded on reset.
REQ-002 Parameter MEM_WAIT_EN, default 1: 1 = honour mem_ready; 0 = treat mem_ready as tied high.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-low.
REQ-005 mem_rd_data  input  32  read data, valid in the cycle mem_ready=1.
REQ-006 mem_ready  input  1  memory completes the current request this cycle.
REQ-007 mem_req  output  1  memory request is active.
REQ-008 mem_we  output  1  write request, qualified by mem_req.
REQ-009 mem_addr  output  32  byte address: PC in FETCH, ALUOut in MEMRD/MEMWR.
REQ-010 mem_wr_data  output  32  B register contents.
REQ-011 pc  output  32  current PC.
REQ-012 state  output  4  FSM state encoding, for debug.
REQ-013 retire  output  1  one-cycle pulse on the final cycle of each completed instruction.
REQ-014 illegal_op  output  1  set when an unsupported opcode or funct is decoded.

Function
REQ-015 The block contains an internal control FSM, so no control signals are accepted from outside.
REQ-016 FSM states: FETCH, DECODE, EXEC, RWB, ADDI_EX, ADDI_WB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, JUMP, ERR.
- Optional state JAL exists only when MIPS_JAL_EN is defined.
REQ-017 FETCH behaviour:
- mem_req=1, mem_we=0.
- On mem_ready: IR <= mem_rd_data, PC <= PC+4, go to DECODE.
- Otherwise hold all state.
REQ-018 DECODE behaviour:
- A <= rs, B <= rt, ALUOut <= PC + (sext(imm)<<2).
- Dispatch: R-type -> EXEC; addi -> ADDI_EX; lw/sw -> MEMADR; beq/bne -> BRANCH; j -> JUMP; anything else -> ERR.
REQ-019 Supported R-type funct: add, sub, and, or, slt (signed), sll, srl.
- Shifts use zero-extended shamt applied to rt.
- Unsupported funct -> ERR.
- add and sub wrap modulo 2^32; no overflow exceptions.
REQ-020 R-type path: EXEC -> RWB; RWB writes rd.
REQ-021 addi path: ADDI_EX -> ADDI_WB; ADDI_WB writes rt with A+sext(imm).
REQ-022 MEMADR computes ALUOut <= A+sext(imm), then goes to MEMRD (lw) or MEMWR (sw).
REQ-023 MEMRD and MEMWR hold mem_req (mem_we=1 for MEMWR) until mem_ready.
- MEMRD then latches MDR and goes to MEMWB, which writes rt.
- MEMWR then retires.
REQ-024 BRANCH:
- beq: PC <= ALUOut if A==B.
- bne: PC <= ALUOut if A!=B.
- Then retire.
REQ-025 JUMP: PC <= {PC[31:28], instr[25:0], 2'b00}, then retire.
REQ-026 Zero-wait latency in cycles: R-type 4, addi 4, lw 5, sw 4, beq/bne 3, j 3.
- Each cycle with mem_ready=0 in a memory state adds one cycle.
REQ-027 Every retiring state asserts retire for exactly one cycle and returns to FETCH.
REQ-028 Writes to register 0 are discarded; register 0 always reads 0.
REQ-029 ERR sets illegal_op=1, drives mem_req=0, and stays in ERR until reset.
REQ-030 The PC wraps modulo 2^32.
- Misaligned addresses are passed to memory unmodified.

Reset
REQ-031 When rst=0 at a clock edge, the block loads:
- PC = RESET_VECTOR and state = FETCH.
- IR, A, B, MDR, ALUOut and all 32 registers = 0.
- illegal_op = 0 and retire = 0.
REQ-032 Reset during any state, including a pending memory wait, abandons the instruction with no register or memory write; mem_req is 0 in the following cycle.
REQ-033 During reset, mem_req=0 and mem_we=0.

Configuration
REQ-034 Macro MIPS_JAL_EN:
- Defined: opcode 6'h03 decodes to state JAL, which writes PC (already PC+4) to register 31, loads the jump target as in JUMP, and retires in 3 cycles.
- Undefined: opcode 6'h03 goes to ERR.

Verification
REQ-035 Reset: hold rst=0 for 2 cycles, then release -> pc=32'h00400000, mem_req=1 in FETCH, mem_addr=32'h00400000.
REQ-036 Program addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,0($0) -> memory write of 32'd12 to address 0; retire count 4 after 16 cycles with zero wait.
REQ-037 lw with mem_ready low for 3 cycles in MEMRD -> 8 cycles to retire; rt holds the loaded word; no extra write occurs.
REQ-038 beq $1,$1,-1 -> PC returns to the same address; bne on equal operands -> PC+4; both take 3 cycles.
REQ-039 Opcode 6'h03 -> illegal_op=1 when the macro is undefined; register 31 = return address and PC = target when MIPS_JAL_EN is defined.
REQ-040 rst=0 asserted in MEMWR while mem_ready=0 -> no write is issued; the core resumes at RESET_VECTOR.
